avalon_camera_csr: RTL
======================

AVALON_CAMERA_CSR -- requirements
Module: avalon_camera_csr

Interface
REQ-001 SHALL have parameter NUM_BUFF, default 2, number of line buffers, legal range 1..8.
REQ-002 SHALL have parameter ADDR_W, default 5, width of the word address.
REQ-003 SHALL have parameter CFG_DEFAULTS, default {320,240,0x0036,0x0010,0x059F,0x077F,0x0002,0x0002,0x07C0}, reset values of cfg words 0..8.
REQ-004 SHALL have input clk, 1 bit, the Avalon clock; all state is on its rising edge.
REQ-005 SHALL have input reset_n, 1 bit, asynchronous, active-low reset.
REQ-006 SHALL have these Avalon slave ports:
  - input avs_address, ADDR_W bits, word address;
  - input avs_read and input avs_write, 1 bit each, strobes;
  - input avs_writedata, 32 bits;
  - output avs_readdata, 32 bits, registered.
REQ-007 SHALL have output cap_start, 1 bit, one-cycle capture start pulse.
REQ-008 SHALL have output cap_continuous, 1 bit, continuous-capture mode level.
REQ-009 SHALL have outputs cap_width and cap_height, 16 bits each, capture geometry.
REQ-010 SHALL have output buff_addr, NUM_BUFF*32 bits, buffer base addresses, buffer i at bits [32i+31:32i].
REQ-011 SHALL have input buff_done_tgl, NUM_BUFF bits; bit i toggles in the capture clock domain each time buffer i fills.
REQ-012 SHALL have output cfg, 144 bits, nine 16-bit camera config words, word k at bits [16k+15:16k].
REQ-013 SHALL have output cam_soft_reset_n, 1 bit, and output irq, 1 bit, level interrupt.

Function
REQ-014 SHALL implement this register map (word addresses); reads of any other address return 0 and writes to them have no effect:
  - 0x00 CTRL: bit0 START, write-1 pulse, reads 0; bit1 CONT, RW; bit2 IRQ_EN, RW.
  - 0x01 WIDTH and 0x02 HEIGHT, 16-bit RW.
  - 0x03 STATUS: FULL at [NUM_BUFF-1:0], OVF at [16+NUM_BUFF-1:16], both write-1-to-clear.
  - 0x04 IRQ_MASK at [NUM_BUFF-1:0], RW.
  - 0x08+i BUFF_ADDR[i], 32-bit RW, for i < NUM_BUFF.
  - 0x10+k CFG[k], 16-bit RW, for k = 0..8.
  - 0x1F SOFT_RESET_N, bit0 RW.
REQ-015 SHALL make avs_readdata valid exactly one cycle after avs_read and hold it until the next read.
REQ-016 SHALL zero-extend 16-bit and 1-bit fields on read; unused bits read 0.
REQ-017 SHALL update a written register on the clk edge where avs_write is high; writes to 16-bit registers use writedata[15:0].
REQ-018 SHALL service avs_read and avs_write asserted in the same cycle to the same address by returning the pre-write value.
REQ-019 SHALL assert cap_start for exactly one cycle, the cycle after a CTRL write with bit0=1; back-to-back writes give back-to-back pulses.
REQ-020 SHALL pass each buff_done_tgl bit through a 2-flop synchronizer, then an edge detector (XOR with a delayed copy), giving event pulse ev[i].
REQ-021 SHALL set FULL[i] exactly 3 clk edges after a toggle settles at the input.
REQ-022 SHALL set OVF[i] when ev[i] arrives while FULL[i] is already 1; FULL[i] stays 1.
REQ-023 SHALL make ev[i] win over a simultaneous W1C of FULL[i] or OVF[i], so the bit remains/becomes 1; W1C with 0 bits leaves those bits unchanged.
REQ-024 SHALL drive irq as a registered IRQ_EN & |(FULL & IRQ_MASK), updating one cycle after its inputs change.
REQ-025 SHALL take the 32-bit registers and the cfg words as 32-bit and 16-bit wide, with no arithmetic and no wrap.

Reset
REQ-026 SHALL, on reset_n low, asynchronously clear all of the following to 0: cap_start, cap_continuous, IRQ_EN, WIDTH, HEIGHT, all BUFF_ADDR, FULL, OVF, IRQ_MASK, irq, avs_readdata and the synchronizer flops.
REQ-027 SHALL, on reset_n low, set cfg to CFG_DEFAULTS and cam_soft_reset_n to 1.
REQ-028 SHALL load the delayed edge-detect copy with the synchronized value on the first clock after reset, so no spurious ev occurs at reset release.
REQ-029 SHALL abort a reset asserted mid-operation immediately, with no partial write committed.

Verification
REQ-030 Reset, then read 0x10..0x18 and 0x1F -> 320, 240, 0x36, 0x10, 0x59F, 0x77F, 2, 2, 0x7C0, then 1; each with readdata[31:16]=0.
REQ-031 Write 0x08=0xDEADBEEF, then read it -> 0xDEADBEEF after 1-cycle latency; buff_addr[31:0]=0xDEADBEEF.
REQ-032 Write CTRL=0x1 twice back-to-back -> cap_start high for 2 consecutive cycles; CTRL then reads 0.
REQ-033 Set IRQ_MASK=0x1 and CTRL=0x4, then toggle buff_done_tgl[0] -> FULL[0]=1 after 3 edges and irq=1 one cycle later; write STATUS=0x1 -> irq=0.
REQ-034 Toggle buff_done_tgl[1] twice without clearing -> STATUS reads 0x00020002.
REQ-035 Land ev[0] on the same edge as a STATUS=0x1 write -> FULL[0] stays 1.

Source files
------------

// File: rtl/avalon_camera_csr.sv
// Avalon-MM control/status registers for a camera capture block. Read data is registered
// (1-cycle latency). Buffer-done toggles are synchronized and raise sticky FULL/OVF flags.
module avalon_camera_csr #(
  parameter int NUM_BUFF = 2,
  parameter int ADDR_W = 5,
  parameter logic [143:0] CFG_DEFAULTS = {16'h07C0, 16'h0002, 16'h0002, 16'h077F,
                                          16'h059F, 16'h0010, 16'h0036, 16'd240, 16'd320}
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ADDR_W-1:0]        avs_address,
  input  logic                     avs_read,
  input  logic                     avs_write,
  input  logic [31:0]              avs_writedata,
  output logic [31:0]              avs_readdata,
  output logic                     cap_start,
  output logic                     cap_continuous,
  output logic [15:0]              cap_width,
  output logic [15:0]              cap_height,
  output logic [NUM_BUFF*32-1:0]   buff_addr,
  input  logic [NUM_BUFF-1:0]      buff_done_tgl,
  output logic [143:0]             cfg,
  output logic                     cam_soft_reset_n,
  output logic                     irq
);

  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] A_WIDTH  = ADDR_W'(8'h01);
  localparam logic [ADDR_W-1:0] A_HEIGHT = ADDR_W'(8'h02);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(8'h03);
  localparam logic [ADDR_W-1:0] A_MASK   = ADDR_W'(8'h04);
  localparam logic [ADDR_W-1:0] A_SRST   = ADDR_W'(8'h1F);

  logic                       irq_en;
  logic [NUM_BUFF-1:0]        full;
  logic [NUM_BUFF-1:0]        ovf;
  logic [NUM_BUFF-1:0]        irq_mask;
  logic [NUM_BUFF-1:0][31:0]  buff_q;
  logic [8:0][15:0]           cfg_q;

  logic [NUM_BUFF-1:0]        sync1;
  logic [NUM_BUFF-1:0]        sync2;
  logic [NUM_BUFF-1:0]        dly;
  logic                       primed;
  logic [NUM_BUFF-1:0]        ev;

  logic [NUM_BUFF-1:0]        clr_full;
  logic [NUM_BUFF-1:0]        clr_ovf;
  logic [NUM_BUFF-1:0]        full_nxt;
  logic [NUM_BUFF-1:0]        ovf_nxt;
  logic [31:0]                rd_mux;

  logic wr_ctrl, wr_width, wr_height, wr_status, wr_mask, wr_srst;

  assign wr_ctrl   = avs_write && (avs_address == A_CTRL);
  assign wr_width  = avs_write && (avs_address == A_WIDTH);
  assign wr_height = avs_write && (avs_address == A_HEIGHT);
  assign wr_status = avs_write && (avs_address == A_STATUS);
  assign wr_mask   = avs_write && (avs_address == A_MASK);
  assign wr_srst   = avs_write && (avs_address == A_SRST);

  assign buff_addr = buff_q;
  assign cfg       = cfg_q;

  // Edge detector is held off until the delayed copy has been primed after reset.
  assign ev = primed ? (sync2 ^ dly) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= '0;
      sync2  <= '0;
      dly    <= '0;
      primed <= 1'b0;
    end else begin
      sync1  <= buff_done_tgl;
      sync2  <= sync1;
      dly    <= sync2;
      primed <= 1'b1;
    end
  end

  // A fresh event beats a simultaneous write-1-to-clear; OVF looks at FULL before this edge.
  always_comb begin
    clr_full = wr_status ? avs_writedata[NUM_BUFF-1:0] : '0;
    clr_ovf  = wr_status ? avs_writedata[16 +: NUM_BUFF] : '0;
    full_nxt = (full & ~clr_full) | ev;
    ovf_nxt  = (ovf & ~clr_ovf) | (ev & full);
  end

  always_comb begin
    rd_mux = '0;
    if (avs_address == A_CTRL)   rd_mux[2:0] = {irq_en, cap_continuous, 1'b0};
    if (avs_address == A_WIDTH)  rd_mux[15:0] = cap_width;
    if (avs_address == A_HEIGHT) rd_mux[15:0] = cap_height;
    if (avs_address == A_STATUS) begin
      rd_mux[NUM_BUFF-1:0]   = full;
      rd_mux[16 +: NUM_BUFF] = ovf;
    end
    if (avs_address == A_MASK)   rd_mux[NUM_BUFF-1:0] = irq_mask;
    if (avs_address == A_SRST)   rd_mux[0] = cam_soft_reset_n;
    for (int i = 0; i < NUM_BUFF; i++)
      if (avs_address == ADDR_W'(8 + i)) rd_mux = buff_q[i];
    for (int k = 0; k < 9; k++)
      if (avs_address == ADDR_W'(16 + k)) rd_mux[15:0] = cfg_q[k];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_start        <= 1'b0;
      cap_continuous   <= 1'b0;
      irq_en           <= 1'b0;
      cap_width        <= '0;
      cap_height       <= '0;
      buff_q           <= '0;
      full             <= '0;
      ovf              <= '0;
      irq_mask         <= '0;
      irq              <= 1'b0;
      avs_readdata     <= '0;
      cfg_q            <= CFG_DEFAULTS;
      cam_soft_reset_n <= 1'b1;
    end else begin
      cap_start <= wr_ctrl && avs_writedata[0];
      if (wr_ctrl) begin
        cap_continuous <= avs_writedata[1];
        irq_en         <= avs_writedata[2];
      end
      if (wr_width)  cap_width  <= avs_writedata[15:0];
      if (wr_height) cap_height <= avs_writedata[15:0];
      if (wr_mask)   irq_mask   <= avs_writedata[NUM_BUFF-1:0];
      if (wr_srst)   cam_soft_reset_n <= avs_writedata[0];
      for (int i = 0; i < NUM_BUFF; i++)
        if (avs_write && (avs_address == ADDR_W'(8 + i))) buff_q[i] <= avs_writedata;
      for (int k = 0; k < 9; k++)
        if (avs_write && (avs_address == ADDR_W'(16 + k))) cfg_q[k] <= avs_writedata[15:0];
      full <= full_nxt;
      ovf  <= ovf_nxt;
      irq  <= irq_en && (|(full & irq_mask));
      // Mux sees pre-write register values, so a same-cycle read/write returns old data.
      if (avs_read) avs_readdata <= rd_mux;
    end
  end

endmodule
